// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1-style TAP controller holding the instruction register plus the
// IDCODE and BYPASS data registers, and steering the GPIO scan chain and TDO.
module jtag_tap #(
  parameter int unsigned        IR_BITS        = 4,
  parameter logic [31:0]        IDCODE_VALUE   = 32'h1000_0001,
  parameter logic [IR_BITS-1:0] IR_IDCODE      = IR_BITS'(4'b0001),
  parameter logic [IR_BITS-1:0] IR_GPIO_DATA   = IR_BITS'(4'b0010),
  parameter logic [IR_BITS-1:0] IR_GPIO_CONFIG = IR_BITS'(4'b0011)
) (
  input  logic tck,
  input  logic reset_,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_oe,
  input  logic gpios_tdo,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic gpio_data_ir,
  output logic gpio_config_ir,
  output logic test_logic_reset
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PA_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PA_IR, S_EX2_IR, S_UPD_IR
  } state_t;

  state_t             state;
  logic [IR_BITS-1:0] ir;
  logic [IR_BITS-1:0] ir_shift;
  logic [31:0]        idcode_dr;
  logic               bypass_dr;
  logic               sel_idcode;
  logic               sel_gpio;
  logic               sel_bypass;

  assign capture_dr       = (state == S_CAP_DR);
  assign shift_dr         = (state == S_SH_DR);
  assign update_dr        = (state == S_UPD_DR);
  assign test_logic_reset = (state == S_TLR);

  // Select lines come from the active ir only, so they stay stable throughout a DR scan.
  assign gpio_data_ir   = (ir == IR_GPIO_DATA);
  assign gpio_config_ir = (ir == IR_GPIO_CONFIG);
  assign sel_idcode     = (ir == IR_IDCODE);
  assign sel_gpio       = gpio_data_ir | gpio_config_ir;
  assign sel_bypass     = !sel_idcode && !sel_gpio;

  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      state <= S_TLR;
    end else begin
      unique case (state)
        S_TLR:    state <= tms ? S_TLR    : S_RTI;
        S_RTI:    state <= tms ? S_SEL_DR : S_RTI;
        S_SEL_DR: state <= tms ? S_SEL_IR : S_CAP_DR;
        S_CAP_DR: state <= tms ? S_EX1_DR : S_SH_DR;
        S_SH_DR:  state <= tms ? S_EX1_DR : S_SH_DR;
        S_EX1_DR: state <= tms ? S_UPD_DR : S_PA_DR;
        S_PA_DR:  state <= tms ? S_EX2_DR : S_PA_DR;
        S_EX2_DR: state <= tms ? S_UPD_DR : S_SH_DR;
        S_UPD_DR: state <= tms ? S_SEL_DR : S_RTI;
        S_SEL_IR: state <= tms ? S_TLR    : S_CAP_IR;
        S_CAP_IR: state <= tms ? S_EX1_IR : S_SH_IR;
        S_SH_IR:  state <= tms ? S_EX1_IR : S_SH_IR;
        S_EX1_IR: state <= tms ? S_UPD_IR : S_PA_IR;
        S_PA_IR:  state <= tms ? S_EX2_IR : S_PA_IR;
        S_EX2_IR: state <= tms ? S_UPD_IR : S_SH_IR;
        S_UPD_IR: state <= tms ? S_SEL_DR : S_RTI;
      endcase
    end
  end

  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      ir       <= IR_IDCODE;
      ir_shift <= '0;
    end else begin
      case (state)
        S_TLR:    ir       <= IR_IDCODE;
        S_CAP_IR: ir_shift <= IR_BITS'(2'b01);
        S_SH_IR:  ir_shift <= {tdi, ir_shift[IR_BITS-1:1]};
        S_UPD_IR: ir       <= ir_shift;
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      idcode_dr <= '0;
      bypass_dr <= 1'b0;
    end else if (state == S_CAP_DR) begin
      if (sel_idcode) idcode_dr <= IDCODE_VALUE;
      if (sel_bypass) bypass_dr <= 1'b0;
    end else if (state == S_SH_DR) begin
      if (sel_idcode) idcode_dr <= {tdi, idcode_dr[31:1]};
      if (sel_bypass) bypass_dr <= tdi;
    end
  end

  // Falling-edge launch gives the downstream device a half cycle of setup before posedge.
  always_ff @(negedge tck or negedge reset_) begin
    if (!reset_) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else if (state == S_SH_IR) begin
      tdo    <= ir_shift[0];
      tdo_oe <= 1'b1;
    end else if (state == S_SH_DR) begin
      tdo_oe <= 1'b1;
      if (sel_gpio)        tdo <= gpios_tdo;
      else if (sel_idcode) tdo <= idcode_dr[0];
      else                 tdo <= bypass_dr;
    end else begin
      tdo_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// tb_jtag_tap: random and directed TMS/TDI stimulus against a queue-based TAP model,
// compared every falling edge, plus literal checks on known scan results.
module tb_jtag_tap;

  localparam int          IRB    = 4;
  localparam logic [31:0] IDC    = 32'h1000_0001;
  localparam logic [3:0]  C_ID   = 4'b0001;
  localparam logic [3:0]  C_DATA = 4'b0010;
  localparam logic [3:0]  C_CFG  = 4'b0011;

  logic tck = 1'b0;
  logic reset_, tms, tdi, gpios_tdo;
  logic tdo, tdo_oe, capture_dr, shift_dr, update_dr;
  logic gpio_data_ir, gpio_config_ir, test_logic_reset;

  jtag_tap #(
    .IR_BITS(IRB), .IDCODE_VALUE(IDC), .IR_IDCODE(C_ID),
    .IR_GPIO_DATA(C_DATA), .IR_GPIO_CONFIG(C_CFG)
  ) dut (
    .tck(tck), .reset_(reset_), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .gpios_tdo(gpios_tdo), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .gpio_data_ir(gpio_data_ir),
    .gpio_config_ir(gpio_config_ir), .test_logic_reset(test_logic_reset)
  );

  always #5 tck = ~tck;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a state is a (phase, side) pair; registers are LSB-first bit queues.
  typedef enum int {K_TLR, K_RTI, K_SEL, K_CAP, K_SHIFT, K_EX1, K_PAUSE, K_EX2, K_UPD} kind_t;
  kind_t      m_kind;
  bit         m_onir;
  logic [3:0] m_ir;
  bit         q_ir[$];
  bit         q_dr[$];
  bit         m_tdo, m_oe;
  logic [31:0] idv;

  function automatic int chain_of(input logic [3:0] code);
    if (code == C_ID) return 0;
    if (code == C_DATA || code == C_CFG) return 1;
    return 2;
  endfunction

  always @(posedge tck) begin
    if (!reset_) begin
      m_kind = K_TLR; m_onir = 0; m_ir = C_ID;
      q_ir.delete();
      for (int i = 0; i < IRB; i++) q_ir.push_back(1'b0);
      q_dr.delete();
    end else begin
      case (m_kind)
        K_TLR: m_ir = C_ID;
        K_CAP: begin
          if (m_onir) begin
            q_ir.delete();
            q_ir.push_back(1'b1);
            for (int i = 1; i < IRB; i++) q_ir.push_back(1'b0);
          end else if (chain_of(m_ir) == 0) begin
            idv = IDC;
            q_dr.delete();
            for (int i = 0; i < 32; i++) q_dr.push_back(idv[i]);
          end else if (chain_of(m_ir) == 2) begin
            q_dr.delete();
            q_dr.push_back(1'b0);
          end
        end
        K_SHIFT: begin
          if (m_onir) begin
            void'(q_ir.pop_front());
            q_ir.push_back(tdi);
          end else if (chain_of(m_ir) != 1) begin
            void'(q_dr.pop_front());
            q_dr.push_back(tdi);
          end
        end
        K_UPD: if (m_onir) for (int i = 0; i < IRB; i++) m_ir[i] = q_ir[i];
        default: ;
      endcase
      case (m_kind)
        K_TLR:   m_kind = tms ? K_TLR : K_RTI;
        K_RTI:   if (tms) begin m_kind = K_SEL; m_onir = 0; end
        K_SEL:   if (!tms) m_kind = K_CAP; else if (!m_onir) m_onir = 1; else m_kind = K_TLR;
        K_CAP:   m_kind = tms ? K_EX1 : K_SHIFT;
        K_SHIFT: if (tms) m_kind = K_EX1;
        K_EX1:   m_kind = tms ? K_UPD : K_PAUSE;
        K_PAUSE: if (tms) m_kind = K_EX2;
        K_EX2:   m_kind = tms ? K_UPD : K_SHIFT;
        K_UPD:   begin m_kind = tms ? K_SEL : K_RTI; m_onir = 0; end
        default: m_kind = K_TLR;
      endcase
    end
  end

  always @(negedge tck) begin
    #1;
    if (!reset_) begin
      m_tdo = 0; m_oe = 0;
      chk("rst_tlr", test_logic_reset, 1);
      chk("rst_decodes", {capture_dr, shift_dr, update_dr}, 0);
      chk("rst_selects", {gpio_data_ir, gpio_config_ir}, 0);
    end else begin
      if (m_kind == K_SHIFT && m_onir) begin
        m_tdo = q_ir[0]; m_oe = 1;
      end else if (m_kind == K_SHIFT) begin
        m_oe = 1;
        m_tdo = (chain_of(m_ir) == 1) ? gpios_tdo : q_dr[0];
      end else begin
        m_oe = 0;
      end
      chk("tlr", test_logic_reset, m_kind == K_TLR);
      chk("capture_dr", capture_dr, m_kind == K_CAP && !m_onir);
      chk("shift_dr", shift_dr, m_kind == K_SHIFT && !m_onir);
      chk("update_dr", update_dr, m_kind == K_UPD && !m_onir);
      chk("gpio_data_ir", gpio_data_ir, m_ir == C_DATA);
      chk("gpio_config_ir", gpio_config_ir, m_ir == C_CFG);
    end
    chk("tdo_oe", tdo_oe, m_oe);
    chk("tdo", tdo, m_tdo);
  end

  logic o_tdo, o_oe;
  int   upd_cnt = 0;
  int   sh_cnt  = 0;
  int   cap_cnt = 0;

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input logic t, input logic d);
    tms = t; tdi = d; gpios_tdo = 1'($urandom_range(0, 1));
    @(negedge tck); #2;
    o_tdo = tdo; o_oe = tdo_oe;
    upd_cnt += int'(update_dr);
    sh_cnt  += int'(shift_dr);
    cap_cnt += int'(capture_dr);
    @(posedge tck); #1;
  endtask

  task automatic goto_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic ir_scan(input logic [3:0] v, output logic [3:0] cap);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IRB; i++) begin
      step(i == IRB - 1, v[i]);
      cap[i] = o_tdo;
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] v, output logic [31:0] got);
    got = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, v[i]);
      got[i] = o_tdo;
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  cap;
    logic [31:0] got;
    int u0, s0, c0, r;
    reset_ = 1; tms = 1; tdi = 0; gpios_tdo = 0;
    #1 reset_ = 0;
    repeat (2) @(posedge tck);
    #1 reset_ = 1;
    chk("lit_tlr_after_reset", test_logic_reset, 1);
    step(0, 0);
    chk("lit_tlr_falls", test_logic_reset, 0);

    dr_scan(32, 32'h0, got);
    chk("lit_idcode_scan", got, 32'h1000_0001);

    ir_scan(4'b0010, cap);
    chk("lit_ir_capture", cap, 4'b0001);
    chk("lit_gpio_data_sel", {gpio_data_ir, gpio_config_ir}, 2'b10);
    u0 = upd_cnt; s0 = sh_cnt; c0 = cap_cnt;
    dr_scan(8, $urandom, got);
    chk("lit_gpio_cap_pulse", cap_cnt - c0, 1);
    chk("lit_gpio_shift_cycles", sh_cnt - s0, 8);
    chk("lit_gpio_upd_pulse", upd_cnt - u0, 1);

    ir_scan(4'b1111, cap);
    dr_scan(4, 32'b1101, got);
    chk("lit_bypass_out", got, 32'b1010);

    ir_scan(C_CFG, cap);
    chk("lit_cfg_sel", {gpio_data_ir, gpio_config_ir}, 2'b01);
    u0 = upd_cnt;
    step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
    repeat (5) step(1, 0);
    chk("lit_tms5_upd_once", upd_cnt - u0, 1);
    chk("lit_tms5_tlr", test_logic_reset, 1);
    step(1, 0);
    chk("lit_tms5_ir_idcode", gpio_config_ir, 0);
    step(0, 0);

    ir_scan(C_CFG, cap);
    u0 = upd_cnt;
    step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
    reset_ = 0; #1;
    chk("lit_rst_immediate_tlr", test_logic_reset, 1);
    chk("lit_rst_ir_idcode", gpio_config_ir, 0);
    step(0, 0); step(1, 0);
    reset_ = 1;
    step(1, 0); step(0, 0);
    chk("lit_rst_no_update", upd_cnt - u0, 0);

    got = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 10; i++) begin step(i == 9, 0); got[i] = o_tdo; end
    step(0, 0);
    for (int i = 0; i < 9; i++) step(0, 1);
    step(1, 0); step(0, 0);
    for (int i = 10; i < 32; i++) begin step(i == 31, 0); got[i] = o_tdo; end
    step(1, 0); step(0, 0);
    chk("lit_pause_idcode", got, IDC);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        goto_rti();
        case ($urandom_range(0, 3))
          0: ir_scan(C_ID, cap);
          1: ir_scan(C_DATA, cap);
          2: ir_scan(C_CFG, cap);
          default: ir_scan(4'($urandom), cap);
        endcase
        chk("rand_ir_capture", cap, 4'b0001);
      end else if (r < 6) begin
        goto_rti();
        dr_scan($urandom_range(1, 32), $urandom, got);
      end else if (r == 6) begin
        reset_ = 0;
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        reset_ = 1;
      end else begin
        repeat (12) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
Name: jtag_tap

Overview:
- IEEE 1149.1-style TAP controller that sits directly upstream of the GPIO scan-chain block.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register.
- Drives capture_dr/shift_dr/update_dr and the per-instruction select lines to the downstream chain.
- Implements the IDCODE and BYPASS data registers and muxes the selected chain onto TDO.

Parameters:
- IR_BITS, 4, instruction register width (min 2).
- IDCODE_VALUE, 32'h1000_0001, value captured by IDCODE (bit 0 must be 1).
- IR_IDCODE, 4'b0001, IDCODE instruction code.
- IR_GPIO_DATA, 4'b0010, selects the GPIO data chain.
- IR_GPIO_CONFIG, 4'b0011, selects the GPIO config chain.
- BYPASS is all-ones and is not a parameter. Unlisted codes behave as BYPASS.

Ports:
- tck  input  1  JTAG clock, the only clock. Flops use posedge; TDO flops use negedge.
- reset_  input  1  asynchronous active-low reset.
- tms  input  1  test mode select, sampled on posedge tck.
- tdi  input  1  test data in.
- tdo  output  1  test data out, registered on negedge tck.
- tdo_oe  output  1  TDO output enable, registered on negedge tck.
- gpios_tdo  input  1  serial output of the downstream GPIO chain.
- capture_dr  output  1  FSM is in CAPTURE_DR.
- shift_dr  output  1  FSM is in SHIFT_DR.
- update_dr  output  1  FSM is in UPDATE_DR.
- gpio_data_ir  output  1  active IR equals IR_GPIO_DATA.
- gpio_config_ir  output  1  active IR equals IR_GPIO_CONFIG.
- test_logic_reset  output  1  FSM is in TEST_LOGIC_RESET.

Behaviour:
- Reset:
  - Async reset_=0 forces state=TEST_LOGIC_RESET, ir=IR_IDCODE, ir_shift=0, idcode_dr=0, bypass_dr=0, tdo=0, tdo_oe=0.
  - On reset, test_logic_reset=1 and all other decode outputs are 0.
- FSM: standard 16 states, advanced on posedge tck by tms.
  - TLR: tms=0 -> RTI; tms=1 -> stays.
  - RTI: tms=0 -> stays; tms=1 -> SELECT_DR.
  - SELECT_DR: tms=0 -> CAPTURE_DR; tms=1 -> SELECT_IR.
  - SELECT_IR: tms=0 -> CAPTURE_IR; tms=1 -> TLR.
  - CAPTURE_x: tms=0 -> SHIFT_x; tms=1 -> EXIT1_x.
  - SHIFT_x: tms=0 -> stays; tms=1 -> EXIT1_x.
  - EXIT1_x: tms=0 -> PAUSE_x; tms=1 -> UPDATE_x.
  - PAUSE_x: tms=0 -> stays; tms=1 -> EXIT2_x.
  - EXIT2_x: tms=0 -> SHIFT_x; tms=1 -> UPDATE_x.
  - UPDATE_x: tms=0 -> RTI; tms=1 -> SELECT_DR.
  - From any state, 5 consecutive tms=1 cycles reach TLR.
- State decodes (capture_dr, shift_dr, update_dr, test_logic_reset) are combinational from the state register. The downstream chain acts on the posedge that ends the state.
- Instruction register:
  - CAPTURE_IR: ir_shift <= {zeros, 2'b01}.
  - SHIFT_IR: ir_shift <= {tdi, ir_shift[IR_BITS-1:1]}.
  - UPDATE_IR: ir <= ir_shift.
  - While in TLR: ir <= IR_IDCODE (synchronous, in addition to the async reset).
  - ir changes only in UPDATE_IR or TLR, never during a DR scan.
- Select lines: gpio_data_ir and gpio_config_ir decode only from ir, not from ir_shift. They are mutually exclusive.
- IDCODE DR, active only when ir==IR_IDCODE:
  - CAPTURE_DR: load IDCODE_VALUE.
  - SHIFT_DR: shift right, tdi into bit 31.
- BYPASS DR, active for any ir not IDCODE/GPIO_DATA/GPIO_CONFIG:
  - CAPTURE_DR: load 0.
  - SHIFT_DR: load tdi.
- TDO mux (evaluated on negedge tck):
  - SHIFT_IR: tdo <= ir_shift[0], tdo_oe <= 1.
  - SHIFT_DR: tdo <= bit 0 of the selected chain (gpios_tdo / idcode_dr[0] / bypass_dr), tdo_oe <= 1.
  - Otherwise: tdo_oe <= 0 and tdo holds its value.
- Effective scan latency: a bit shifted in appears on tdo after IDCODE 32, BYPASS 1, IR IR_BITS posedges.
- reset_ asserted mid-scan aborts immediately. No update is issued, ir reverts to IDCODE, and update_dr never pulses.
- PAUSE states hold all shift registers unchanged.

Test Plan:
- Assert reset_=0, then release; hold tms=0 -> state RTI after 1 tck, test_logic_reset falls, ir=4'b0001.
- From RTI, DR scan of 32 bits with tdi=0 -> tdo sequence LSB-first equals 32'h1000_0001, tdo_oe=1 only during SHIFT_DR.
- IR scan shifting in 4'b0010 -> tdo shows captured 1,0,0,0 (LSB-first). After UPDATE_IR, gpio_data_ir=1 and gpio_config_ir=0; a DR scan pulses capture_dr/shift_dr/update_dr and tdo follows gpios_tdo.
- Load IR 4'b1111 (BYPASS) and shift pattern 1,0,1,1 on tdi -> tdo outputs 0 then 1,0,1 (one-cycle delay).
- Mid-SHIFT_DR under GPIO_CONFIG, hold tms=1 for 5 tck -> passes EXIT1/UPDATE (update_dr pulses once), ends in TLR with ir=IDCODE. Repeat with reset_ pulsed instead -> no update_dr pulse, immediate TLR.
- Enter PAUSE_DR mid IDCODE scan for 10 cycles, then resume via EXIT2 -> remaining bits continue with no bit lost or duplicated.
